// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-port DDR RAM arbiter.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 32;
  localparam int LEN_W      = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    BRESP,
    RDATA
  } arb_state_e;

endpackage

// File: rtl/ram_arb_rr.sv
// Grant policy for the RAM arbiter: round-robin by default, or port-1 priority
// with a port-0 starvation counter when RAM_ARB_PRIO_EN is defined.
module ram_arb_rr #(
  parameter int STARVE_LIMIT = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       en,
`ifdef RAM_ARB_PRIO_EN
  input  logic       owner_is_0,
`endif
  output logic       grant
);

`ifdef RAM_ARB_PRIO_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             starved;

  assign starved = (wait_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    grant = req[1];
    if (req == 2'b11) grant = ~starved;
  end

  // Counts cycles port 0 is requesting but not holding the slave; saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (en && !grant) begin
      wait_cnt <= '0;
    end else if (req[0] && !owner_is_0 && !starved) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic last_grant;

  always_comb begin
    grant = req[1];
    if (req == 2'b11) grant = ~last_grant;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (en) begin
      last_grant <= grant;
    end
  end

  // The starvation limit only matters for the priority policy.
  if (STARVE_LIMIT < 1) begin : g_limit_unused
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-port AXI-style arbiter in front of the DDR SDRAM controller; one whole
// burst in flight at a time. Optional macro: RAM_ARB_PRIO_EN (port-1 priority).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  // requester 0
  input  logic                m0_arw_valid,
  output logic                m0_arw_ready,
  input  logic [ADDR_W-1:0]   m0_arw_addr,
  input  logic [LEN_W-1:0]    m0_arw_len,
  input  logic                m0_arw_write,
  input  logic                m0_w_valid,
  output logic                m0_w_ready,
  input  logic [DATA_W-1:0]   m0_w_data,
  input  logic [DATA_W/8-1:0] m0_w_strb,
  input  logic                m0_w_last,
  output logic                m0_b_valid,
  input  logic                m0_b_ready,
  output logic                m0_r_valid,
  input  logic                m0_r_ready,
  output logic [DATA_W-1:0]   m0_r_data,
  output logic                m0_r_last,
  // requester 1
  input  logic                m1_arw_valid,
  output logic                m1_arw_ready,
  input  logic [ADDR_W-1:0]   m1_arw_addr,
  input  logic [LEN_W-1:0]    m1_arw_len,
  input  logic                m1_arw_write,
  input  logic                m1_w_valid,
  output logic                m1_w_ready,
  input  logic [DATA_W-1:0]   m1_w_data,
  input  logic [DATA_W/8-1:0] m1_w_strb,
  input  logic                m1_w_last,
  output logic                m1_b_valid,
  input  logic                m1_b_ready,
  output logic                m1_r_valid,
  input  logic                m1_r_ready,
  output logic [DATA_W-1:0]   m1_r_data,
  output logic                m1_r_last,
  // slave (controller) side
  output logic                s_arw_valid,
  input  logic                s_arw_ready,
  output logic [ADDR_W-1:0]   s_arw_addr,
  output logic [LEN_W-1:0]    s_arw_len,
  output logic                s_arw_write,
  output logic                s_w_valid,
  input  logic                s_w_ready,
  output logic [DATA_W-1:0]   s_w_data,
  output logic [DATA_W/8-1:0] s_w_strb,
  output logic                s_w_last,
  input  logic                s_b_valid,
  output logic                s_b_ready,
  input  logic                s_r_valid,
  output logic                s_r_ready,
  input  logic [DATA_W-1:0]   s_r_data,
  input  logic                s_r_last,
  output logic                grant,
  output arb_state_e          state
);

  // A transfer happens on a channel only in the cycle where both valid and
  // ready are high at the rising clock edge; valid never waits on ready.

  arb_state_e state_q, state_d;
  logic       grant_q, rr_grant, rr_en;
  logic       sel;
  logic       arw_valid_g, arw_write_g, w_valid_g, w_last_g, b_ready_g, r_ready_g;
  logic       in_addr, in_wdata, in_bresp, in_rdata;

  ram_arb_rr #(.STARVE_LIMIT(STARVE_LIMIT)) u_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       ({m1_arw_valid, m0_arw_valid}),
    .en        (rr_en),
`ifdef RAM_ARB_PRIO_EN
    .owner_is_0((state_q != IDLE) && !grant_q),
`endif
    .grant     (rr_grant)
  );

  assign sel   = grant_q;
  assign grant = grant_q;
  assign state = state_q;

  assign arw_valid_g = sel ? m1_arw_valid : m0_arw_valid;
  assign arw_write_g = sel ? m1_arw_write : m0_arw_write;
  assign w_valid_g   = sel ? m1_w_valid   : m0_w_valid;
  assign w_last_g    = sel ? m1_w_last    : m0_w_last;
  assign b_ready_g   = sel ? m1_b_ready   : m0_b_ready;
  assign r_ready_g   = sel ? m1_r_ready   : m0_r_ready;

  assign in_addr  = (state_q == ADDR);
  assign in_wdata = (state_q == WDATA);
  assign in_bresp = (state_q == BRESP);
  assign in_rdata = (state_q == RDATA);

  // Payload muxes run freely; only valid/ready are gated by the state.
  assign s_arw_addr  = sel ? m1_arw_addr : m0_arw_addr;
  assign s_arw_len   = sel ? m1_arw_len  : m0_arw_len;
  assign s_arw_write = arw_write_g;
  assign s_w_data    = sel ? m1_w_data   : m0_w_data;
  assign s_w_strb    = sel ? m1_w_strb   : m0_w_strb;
  assign s_w_last    = w_last_g;
  assign m0_r_data   = s_r_data;
  assign m1_r_data   = s_r_data;
  assign m0_r_last   = s_r_last;
  assign m1_r_last   = s_r_last;

  assign s_arw_valid  = in_addr & arw_valid_g;
  assign m0_arw_ready = in_addr & ~sel & s_arw_ready;
  assign m1_arw_ready = in_addr &  sel & s_arw_ready;
  assign s_w_valid    = in_wdata & w_valid_g;
  assign m0_w_ready   = in_wdata & ~sel & s_w_ready;
  assign m1_w_ready   = in_wdata &  sel & s_w_ready;
  assign s_b_ready    = in_bresp & b_ready_g;
  assign m0_b_valid   = in_bresp & ~sel & s_b_valid;
  assign m1_b_valid   = in_bresp &  sel & s_b_valid;
  assign s_r_ready    = in_rdata & r_ready_g;
  assign m0_r_valid   = in_rdata & ~sel & s_r_valid;
  assign m1_r_valid   = in_rdata &  sel & s_r_valid;

  always_comb begin
    state_d = state_q;
    rr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_arw_valid || m1_arw_valid) begin
          rr_en   = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR:  if (arw_valid_g && s_arw_ready) state_d = arw_write_g ? WDATA : RDATA;
      WDATA: if (w_valid_g && s_w_ready && w_last_g) state_d = BRESP;
      BRESP: if (s_b_valid && b_ready_g) state_d = IDLE;
      RDATA: if (s_r_valid && r_ready_g && s_r_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (rr_en) grant_q <= rr_grant;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed bursts, reset cases and random request mixes
// checked against a grant/ordering model and per-beat expected data.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int LIMIT  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  logic [1:0]        m_arw_valid, m_arw_write, m_w_valid, m_w_last, m_b_ready, m_r_ready;
  logic [ADDR_W-1:0] m_arw_addr [2];
  logic [7:0]        m_arw_len  [2];
  logic [DATA_W-1:0] m_w_data   [2];
  logic [STRB_W-1:0] m_w_strb   [2];
  wire  [1:0]        m_arw_ready, m_w_ready, m_b_valid, m_r_valid, m_r_last;
  wire  [DATA_W-1:0] m_r_data   [2];

  logic              s_arw_ready, s_w_ready, s_b_valid, s_r_valid, s_r_last;
  logic [DATA_W-1:0] s_r_data;
  wire               s_arw_valid, s_arw_write, s_w_valid, s_w_last, s_b_ready, s_r_ready;
  wire  [ADDR_W-1:0] s_arw_addr;
  wire  [7:0]        s_arw_len;
  wire  [DATA_W-1:0] s_w_data;
  wire  [STRB_W-1:0] s_w_strb;
  wire               grant;
  arb_state_e        state;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit last_grant = 1'b1;
  int m0_req_cyc = 0;

  logic [ADDR_W-1:0] req_addr [2];
  int                req_len  [2];
  bit                req_write[2];
  logic [DATA_W-1:0] wbeat [2][16];
  logic [DATA_W-1:0] rbeat [2][16];
  logic [STRB_W-1:0] wstrb [2][16];

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_arw_valid(m_arw_valid[0]), .m0_arw_ready(m_arw_ready[0]), .m0_arw_addr(m_arw_addr[0]),
    .m0_arw_len(m_arw_len[0]), .m0_arw_write(m_arw_write[0]),
    .m0_w_valid(m_w_valid[0]), .m0_w_ready(m_w_ready[0]), .m0_w_data(m_w_data[0]),
    .m0_w_strb(m_w_strb[0]), .m0_w_last(m_w_last[0]),
    .m0_b_valid(m_b_valid[0]), .m0_b_ready(m_b_ready[0]),
    .m0_r_valid(m_r_valid[0]), .m0_r_ready(m_r_ready[0]), .m0_r_data(m_r_data[0]), .m0_r_last(m_r_last[0]),
    .m1_arw_valid(m_arw_valid[1]), .m1_arw_ready(m_arw_ready[1]), .m1_arw_addr(m_arw_addr[1]),
    .m1_arw_len(m_arw_len[1]), .m1_arw_write(m_arw_write[1]),
    .m1_w_valid(m_w_valid[1]), .m1_w_ready(m_w_ready[1]), .m1_w_data(m_w_data[1]),
    .m1_w_strb(m_w_strb[1]), .m1_w_last(m_w_last[1]),
    .m1_b_valid(m_b_valid[1]), .m1_b_ready(m_b_ready[1]),
    .m1_r_valid(m_r_valid[1]), .m1_r_ready(m_r_ready[1]), .m1_r_data(m_r_data[1]), .m1_r_last(m_r_last[1]),
    .s_arw_valid(s_arw_valid), .s_arw_ready(s_arw_ready), .s_arw_addr(s_arw_addr),
    .s_arw_len(s_arw_len), .s_arw_write(s_arw_write),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_last(s_r_last),
    .grant(grant), .state(state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int g);
    return (g != 0) ? 2'b10 : 2'b01;
  endfunction

  // Expected owner of the next burst given which ports are requesting.
  function automatic bit model_winner(input bit [1:0] pend);
    if (pend != 2'b11) return pend[1];
`ifdef RAM_ARB_PRIO_EN
    return !((cyc - m0_req_cyc) >= LIMIT);
`else
    return !last_grant;
`endif
  endfunction

  task automatic clear_inputs();
    m_arw_valid = '0; m_arw_write = '0; m_w_valid = '0; m_w_last = '0;
    m_b_ready = '0; m_r_ready = '0;
    for (int p = 0; p < 2; p++) begin
      m_arw_addr[p] = '0; m_arw_len[p] = '0; m_w_data[p] = '0; m_w_strb[p] = '0;
    end
    s_arw_ready = 1'b0; s_w_ready = 1'b0; s_b_valid = 1'b0;
    s_r_valid = 1'b0; s_r_last = 1'b0; s_r_data = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_state", state, IDLE);
    chk("rst_grant", grant, 0);
    chk("rst_s_valids", {s_arw_valid, s_w_valid, s_b_ready, s_r_ready}, 0);
    chk("rst_m_arw_ready", m_arw_ready, 0);
    chk("rst_m_w_ready", m_w_ready, 0);
    chk("rst_m_b_valid", m_b_valid, 0);
    chk("rst_m_r_valid", m_r_valid, 0);
    clear_inputs();
    last_grant = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // driver: present a request on port p
  task automatic set_req(input int p, input logic [ADDR_W-1:0] addr, input int len,
                         input bit wr, input bit early);
    req_addr[p] = addr; req_len[p] = len; req_write[p] = wr;
    for (int i = 0; i < 16; i++) begin
      wbeat[p][i] = $urandom;
      rbeat[p][i] = $urandom;
      wstrb[p][i] = STRB_W'($urandom_range(1, 15));
    end
    m_arw_valid[p] = 1'b1; m_arw_addr[p] = addr; m_arw_len[p] = 8'(len); m_arw_write[p] = wr;
    if (p == 0) m0_req_cyc = cyc;
    if (wr && early) begin
      m_w_valid[p] = 1'b1; m_w_data[p] = wbeat[p][0];
      m_w_strb[p] = wstrb[p][0]; m_w_last[p] = (len == 0);
    end
  endtask

  // IDLE bubble, arbitration and address handshake; starts/ends at posedge+1.
  task automatic serve(input bit [1:0] pend, output int g, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    g = int'(model_winner(pend));
    last_grant = (g != 0);
    chk("idle_s_arw_valid", s_arw_valid, 0);
    chk("idle_state", state, IDLE);
    chk("idle_m_arw_ready", m_arw_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("arb_latency", s_arw_valid, 1);
    for (int n = 0; n < 20 && s_arw_valid !== 1'b1; n++) begin
      @(posedge clk); #1; @(negedge clk);
    end
    if (s_arw_valid !== 1'b1) begin
      chk("arw_timeout", s_arw_valid, 1);
      @(posedge clk); #1;
      return;
    end
    chk("grant", grant, g);
    chk("s_arw_addr", s_arw_addr, req_addr[g]);
    chk("s_arw_len", s_arw_len, req_len[g]);
    chk("s_arw_write", s_arw_write, req_write[g]);
    chk("arw_ready_before", m_arw_ready, 0);
    chk("no_w_before_addr", s_w_valid, 0);
    chk("w_ready_before_addr", m_w_ready, 0);
    s_arw_ready = 1'b1;
    #1;
    chk("arw_ready_fwd", m_arw_ready, onehot(g));
    chk("no_w_during_addr", s_w_valid, 0);
    chk("w_ready_during_addr", m_w_ready, 0);
    @(posedge clk); #1;
    s_arw_ready = 1'b0;
    m_arw_valid[g] = 1'b0;
    ok = 1'b1;
  endtask

  task automatic do_read(input int g, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_r_valid = 1'b0; m_r_ready[g] = 1'b1;
        @(negedge clk);
        chk("r_gap_valid", m_r_valid, 0);
        chk("r_gap_state", state, RDATA);
        @(posedge clk); #1;
      end
      s_r_valid = 1'b1; s_r_data = rbeat[g][i]; s_r_last = (i == req_len[g]); m_r_ready[g] = 1'b1;
      @(negedge clk);
      chk("r_valid_route", m_r_valid, onehot(g));
      chk("r_data", m_r_data[g], rbeat[g][i]);
      chk("r_last", m_r_last[g], (i == req_len[g]));
      chk("s_r_ready", s_r_ready, 1);
      @(posedge clk); #1;
    end
    s_r_valid = 1'b0; s_r_last = 1'b0; m_r_ready[g] = 1'b0;
  endtask

  task automatic do_write(input int g);
    for (int i = 0; i <= req_len[g]; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        m_w_valid[g] = 1'b0; s_w_ready = 1'b1;
        @(negedge clk);
        chk("w_gap_valid", s_w_valid, 0);
        chk("w_gap_state", state, WDATA);
        @(posedge clk); #1;
      end
      m_w_valid[g] = 1'b1; m_w_data[g] = wbeat[g][i]; m_w_strb[g] = wstrb[g][i];
      m_w_last[g] = (i == req_len[g]); s_w_ready = 1'b1;
      @(negedge clk);
      chk("s_w_valid", s_w_valid, 1);
      chk("s_w_data", s_w_data, wbeat[g][i]);
      chk("s_w_strb", s_w_strb, wstrb[g][i]);
      chk("s_w_last", s_w_last, (i == req_len[g]));
      chk("w_ready_route", m_w_ready, onehot(g));
      @(posedge clk); #1;
    end
    m_w_valid[g] = 1'b0; m_w_last[g] = 1'b0; s_w_ready = 1'b0;
    @(negedge clk);
    chk("bresp_state", state, BRESP);
    chk("b_before_slave", m_b_valid, 0);
    @(posedge clk); #1;
    s_b_valid = 1'b1; m_b_ready[g] = 1'b1;
    @(negedge clk);
    chk("b_valid_route", m_b_valid, onehot(g));
    chk("s_b_ready", s_b_ready, 1);
    @(posedge clk); #1;
    s_b_valid = 1'b0; m_b_ready[g] = 1'b0;
  endtask

  task automatic run_pending(input bit [1:0] pend_in);
    bit [1:0] pend;
    int g;
    bit ok;
    pend = pend_in;
    while (pend != 2'b00) begin
      serve(pend, g, ok);
      if (!ok) begin
        m_arw_valid = '0; m_w_valid = '0;
        pend = 2'b00;
      end else begin
        if (req_write[g]) do_write(g);
        else do_read(g, req_len[g] + 1);
        pend[g] = 1'b0;
      end
    end
    @(negedge clk);
    chk("end_idle_state", state, IDLE);
    chk("end_idle_arw", s_arw_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int g;
    bit ok;
    bit [1:0] pat;
    clear_inputs();
    #1;
    do_reset();

    // single read on port 0
    set_req(0, 28'h100, 3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) rbeat[0][i] = 32'hA0 + i;
    run_pending(2'b01);

    // single write on port 1
    set_req(1, 28'h2000, 1, 1'b1, 1'b0);
    wbeat[1][0] = 32'h11; wbeat[1][1] = 32'h22;
    wstrb[1][0] = 4'hF;   wstrb[1][1] = 4'hF;
    run_pending(2'b10);

    // simultaneous requests from reset, then a third tie
    do_reset();
    set_req(0, 28'h0300, 1, 1'b0, 1'b0);
    set_req(1, 28'h0500, 2, 1'b1, 1'b0);
    run_pending(2'b11);
    set_req(0, 28'h0340, 0, 1'b1, 1'b0);
    set_req(1, 28'h0540, 1, 1'b0, 1'b0);
    run_pending(2'b11);

    // write data presented before the address handshake
    set_req(0, 28'h0340, 2, 1'b1, 1'b1);
    run_pending(2'b01);

    // reset during beat 2 of an 8-beat read
    set_req(0, 28'h0800, 7, 1'b0, 1'b0);
    serve(2'b01, g, ok);
    if (ok) do_read(0, 2);
    s_r_valid = 1'b1; s_r_data = rbeat[0][2]; m_r_ready[0] = 1'b1;
    #2;
    do_reset();
    set_req(1, ADDR_W'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    run_pending(2'b10);

`ifdef RAM_ARB_PRIO_EN
    // port 1 streams len-0 reads while port 0 waits for its turn
    begin
      bit [1:0] pend;
      set_req(0, 28'h0400, 0, 1'b0, 1'b0);
      set_req(1, 28'h0800, 0, 1'b0, 1'b0);
      pend = 2'b11;
      for (int k = 0; k < 8 && pend[0]; k++) begin
        serve(pend, g, ok);
        if (!ok) break;
        do_read(g, 1);
        pend[g] = 1'b0;
        if (g == 1) begin
          set_req(1, 28'h0800 + ADDR_W'(k * 64), 0, 1'b0, 1'b0);
          pend[1] = 1'b1;
        end
      end
      run_pending(pend);
      set_req(0, 28'h0440, 0, 1'b0, 1'b0);
      set_req(1, 28'h0880, 0, 1'b0, 1'b0);
      run_pending(2'b11);
    end
`endif

    // random request mixes
    for (int r = 0; r < 30; r++) begin
      pat = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        if (pat[p]) begin
          set_req(p, ADDR_W'($urandom), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
      end
      run_pending(pat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single DDR SDRAM controller port between two AXI4 requesters that use a combined read/write address channel (arw + write flag).
- Port 0 is the CPU crossbar RAM bus. Port 1 is a DMA/video master.
- Sits between the requesters and the ddr_sdram_ctrl awvalid/arvalid glue.
- Serialises whole bursts: exactly one transaction is outstanding at a time, so the slave side needs no ID.

Parameters:
ADDR_W, 28, arw address width (same on both ports and slave)
DATA_W, 32, data width; strobe width is DATA_W/8
STARVE_LIMIT, 64, only used with RAM_ARB_PRIO_EN; max cycles port 0 may wait while port 1 is favoured

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous reset, active low
mN_arw_valid / mN_arw_ready  in/out  1  address handshake, requester N (N=0,1)
mN_arw_addr  in  ADDR_W  byte address
mN_arw_len  in  8  burst length minus 1
mN_arw_write  in  1  1 = write burst, 0 = read burst
mN_w_valid / mN_w_ready  in/out  1  write-data handshake
mN_w_data  in  DATA_W  write data
mN_w_strb  in  DATA_W/8  byte strobes
mN_w_last  in  1  last beat
mN_b_valid / mN_b_ready  out/in  1  write response
mN_r_valid / mN_r_ready  out/in  1  read data handshake
mN_r_data  out  DATA_W  read data
mN_r_last  out  1  last read beat
s_arw_valid / s_arw_ready  out/in  1  slave address handshake
s_arw_addr, s_arw_len, s_arw_write  out  ADDR_W, 8, 1  granted request fields
s_w_valid / s_w_ready  out/in  1  slave write data
s_w_data, s_w_strb, s_w_last  out  DATA_W, DATA_W/8, 1  forwarded write beat
s_b_valid / s_b_ready  in/out  1  slave write response
s_r_valid / s_r_ready  in/out  1  slave read data
s_r_data, s_r_last  in  DATA_W, 1  slave read beat
grant  out  1  index of the port currently owning the slave (debug/perf)

Behaviour:
- **States:** IDLE, ADDR, WDATA, BRESP, RDATA. State, grant and last_grant are registered.
- **Reset** (async assert, sync release):
  - State IDLE, grant=0, last_grant=1.
  - All valid and ready outputs are 0.
  - Data outputs are don't-care but driven from the muxes.
- **IDLE:**
  - No handshake outputs are asserted.
  - If any mN_arw_valid is high, register grant and go to ADDR.
  - Round-robin: if both ports request, grant = ~last_grant. Otherwise grant the single requester.
  - last_grant updates on the transition to ADDR.
  - Arbitration latency is one cycle: the earliest arw handshake is the cycle after mN_arw_valid rises.
- **ADDR:**
  - s_arw_* = m[grant].arw_*.
  - m[grant].arw_ready = s_arw_ready.
  - On handshake: go to WDATA if write, else RDATA.
- **WDATA:**
  - s_w_* = m[grant].w_* and m[grant].w_ready = s_w_ready.
  - On a beat with w_last: go to BRESP.
  - w beats are never accepted before the address handshake completes.
  - Beat count is not checked; w_last alone terminates the phase.
- **BRESP:**
  - m[grant].b_valid = s_b_valid and s_b_ready = m[grant].b_ready.
  - On handshake: go to IDLE.
- **RDATA:**
  - m[grant].r_* = s_r_* and s_r_ready = m[grant].r_ready.
  - On a beat with r_last: go to IDLE.
- **Non-granted port and inactive channels:**
  - All readies and valids toward the non-granted port are 0.
  - Inactive channels of the granted port are also 0.
  - s_*_ready on inactive slave channels is 0.
- **Combinational paths:** all forwarding is combinational (no added beat latency). Valid/ready are mux-gated only by registered state.
- **Back-to-back:** IDLE is always visited between bursts, which costs one bubble cycle per burst.
- **Requester drops arw_valid in ADDR** (illegal AXI): remain in ADDR; no recovery is required.
- **Reset mid-burst:** state returns to IDLE immediately. The slave shares the same reset, so no drain is performed.

Optional Feature:
- **RAM_ARB_PRIO_EN defined:**
  - Port 1 wins ties instead of round-robin.
  - A wait counter (width clog2(STARVE_LIMIT+1)) counts cycles in which m0_arw_valid is high and port 0 is not granted. It saturates.
  - When the counter reaches STARVE_LIMIT, port 0 wins the next tie.
  - The counter clears when port 0 is granted.
- **RAM_ARB_PRIO_EN undefined:** pure round-robin as above; no counter logic is present.

Decomposition:
- **Package ram_arb_pkg:**
  - State enum (IDLE, ADDR, WDATA, BRESP, RDATA).
  - Default widths ADDR_W=28, DATA_W=32, LEN_W=8.
- **Sub-module ram_arb_rr:** pick/last_grant logic, including the optional starvation counter. Inputs: two request bits and an enable. Output: grant. This keeps the FSM/mux module free of policy.

Test Plan:
1. **Single read.** m0 reads addr 0x100, len 3. Slave returns 4 beats 0xA0..0xA3. Expect:
   - s_arw_valid one cycle after request, s_arw_len=3, write=0.
   - m0 sees 4 beats, r_last on 0xA3.
   - m1 never sees r_valid; FSM returns to IDLE.
2. **Single write.** m1 writes addr 0x2000, len 1, data 0x11, 0x22, strb 0xF. Expect:
   - s_w beats unchanged, s_w_last on 0x22.
   - m1_b_valid only after the slave b handshake; m0 sees no b_valid.
3. **Simultaneous requests from reset.** m0 and m1 both assert arw in the same cycle. Expect:
   - m0 granted first (last_grant=1), then m1 next with one IDLE bubble between bursts.
   - A third simultaneous pair is granted to m0 again.
4. **Early w_valid.** m0 write with w_valid high before the address handshake. Expect:
   - m0_w_ready=0 until s_arw handshake; no s_w_valid before then.
   - Data is intact afterwards.
5. **Mid-burst reset.** reset_n low during beat 2 of an 8-beat read. Expect:
   - All valid/ready outputs 0 asynchronously, grant=0.
   - After release, a fresh m1 request is served normally.
6. **Starvation limit (RAM_ARB_PRIO_EN, STARVE_LIMIT=4).** m1 issues continuous len-0 reads while m0 requests. Expect:
   - m1 wins until port 0 has waited 4 cycles.
   - m0 is then granted; its counter clears.
